sprite_draw_queue: RTL and testbench

// - Frame-staged FIFO of sprite draw commands (id, x, y, scale) between spi_driver (producer) and sprite_driver (consumer).
// - SPI-side entries are staged invisibly until a commit pulse publishes them, so the consumer never starts on a half-sent frame.
// - First-word-fall-through registered head output, matching the dequeue/is_empty interface of sprite_driver.

---
 rtl/sprite_draw_queue_if.sv | 56 +++++
 rtl/sprite_draw_queue.sv | 140 ++++++++++++++
 tb/tb_sprite_draw_queue.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/sprite_draw_queue_if.sv
// Bundles the producer (SPI side) and consumer (sprite_driver side) signals of sprite_draw_queue.
// With SPRITE_QUEUE_STATS_EN defined, the interface also carries drop_count and high_water.
interface sprite_draw_queue_if #(
    parameter int DEPTH   = 64,
    parameter int ID_W    = 8,
    parameter int POS_W   = 16,
    parameter int SCALE_W = 8
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic               enqueue;
    logic [ID_W-1:0]    in_id;
    logic [POS_W-1:0]   in_x;
    logic [POS_W-1:0]   in_y;
    logic [SCALE_W-1:0] in_scale;
    logic               commit;
    logic               discard;
    logic               full;
    logic               overflow;

    logic               dequeue;
    logic               is_empty;
    logic [ID_W-1:0]    sprite_id;
    logic [POS_W-1:0]   sprite_x;
    logic [POS_W-1:0]   sprite_y;
    logic [SCALE_W-1:0] sprite_scale;
    logic [CNT_W-1:0]   count;

`ifdef SPRITE_QUEUE_STATS_EN
    logic [15:0]        drop_count;
    logic [CNT_W-1:0]   high_water;

    modport master (
        output enqueue, in_id, in_x, in_y, in_scale, commit, discard, dequeue,
        input  full, overflow, is_empty, sprite_id, sprite_x, sprite_y, sprite_scale, count,
        input  drop_count, high_water
    );

    modport slave (
        input  enqueue, in_id, in_x, in_y, in_scale, commit, discard, dequeue,
        output full, overflow, is_empty, sprite_id, sprite_x, sprite_y, sprite_scale, count,
        output drop_count, high_water
    );
`else
    modport master (
        output enqueue, in_id, in_x, in_y, in_scale, commit, discard, dequeue,
        input  full, overflow, is_empty, sprite_id, sprite_x, sprite_y, sprite_scale, count
    );

    modport slave (
        input  enqueue, in_id, in_x, in_y, in_scale, commit, discard, dequeue,
        output full, overflow, is_empty, sprite_id, sprite_x, sprite_y, sprite_scale, count
    );
`endif

endinterface

// File: rtl/sprite_draw_queue.sv
// Frame-staged FWFT queue of sprite draw commands: enqueued entries stay invisible until commit.
// Optional statistics (drop_count, high_water) are built when SPRITE_QUEUE_STATS_EN is defined.
module sprite_draw_queue #(
    parameter int DEPTH   = 64,
    parameter int ID_W    = 8,
    parameter int POS_W   = 16,
    parameter int SCALE_W = 8
) (
    input logic                  clock,
    input logic                  reset,
    sprite_draw_queue_if.slave   bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    typedef struct packed {
        logic [ID_W-1:0]    id;
        logic [POS_W-1:0]   x;
        logic [POS_W-1:0]   y;
        logic [SCALE_W-1:0] scale;
    } entry_t;

    entry_t         mem_q [DEPTH];

    logic [PW-1:0]  wrPtr_q, wrPtr_d;
    logic [PW-1:0]  commitPtr_q, commitPtr_d;
    logic [PW-1:0]  rdPtr_q, rdPtr_d;
    logic           full_q, full_d;
    logic           isEmpty_q, isEmpty_d;
    logic           overflow_q, overflow_d;
    logic [PW-1:0]  count_q, count_d;
    entry_t         head_q, head_d;

    logic           dropByDiscard;
    logic           dropByFull;
    logic           accept;
    logic           pop;
    logic [PW-1:0]  wrAdvanced;
    entry_t         inEntry;

    assign inEntry = '{id: bus.in_id, x: bus.in_x, y: bus.in_y, scale: bus.in_scale};

    // Next-state for all pointers and flags. Commit beats discard, and a discard
    // swallows a same-cycle enqueue silently. A bare discard or commit clears overflow
    // even if an enqueue is dropped for fullness in that same cycle.
    always_comb begin
        dropByDiscard = bus.enqueue && bus.discard && !bus.commit;
        dropByFull    = bus.enqueue && full_q && !dropByDiscard;
        accept        = bus.enqueue && !full_q && !dropByDiscard;
        pop           = bus.dequeue && !isEmpty_q;

        wrAdvanced  = wrPtr_q + PW'(accept);
        wrPtr_d     = (bus.discard && !bus.commit) ? commitPtr_q : wrAdvanced;
        commitPtr_d = bus.commit ? wrAdvanced : commitPtr_q;
        rdPtr_d     = rdPtr_q + PW'(pop);

        isEmpty_d  = (rdPtr_d == commitPtr_d);
        full_d     = ((wrPtr_d - rdPtr_d) == PW'(DEPTH));
        count_d    = commitPtr_d - rdPtr_d;
        overflow_d = (bus.commit || bus.discard) ? 1'b0 : (overflow_q || dropByFull);

        // The head may be the very entry being written this cycle (commit with enqueue
        // into an empty queue), so forward it around the RAM.
        head_d = head_q;
        if (!isEmpty_d) begin
            if (accept && (wrPtr_q[AW-1:0] == rdPtr_d[AW-1:0])) begin
                head_d = inEntry;
            end else begin
                head_d = mem_q[rdPtr_d[AW-1:0]];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (accept) begin
            mem_q[wrPtr_q[AW-1:0]] <= inEntry;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wrPtr_q     <= '0;
            commitPtr_q <= '0;
            rdPtr_q     <= '0;
            full_q      <= 1'b0;
            isEmpty_q   <= 1'b1;
            overflow_q  <= 1'b0;
            count_q     <= '0;
            head_q      <= '0;
        end else begin
            wrPtr_q     <= wrPtr_d;
            commitPtr_q <= commitPtr_d;
            rdPtr_q     <= rdPtr_d;
            full_q      <= full_d;
            isEmpty_q   <= isEmpty_d;
            overflow_q  <= overflow_d;
            count_q     <= count_d;
            head_q      <= head_d;
        end
    end

    assign bus.full         = full_q;
    assign bus.overflow     = overflow_q;
    assign bus.is_empty     = isEmpty_q;
    assign bus.count        = count_q;
    assign bus.sprite_id    = head_q.id;
    assign bus.sprite_x     = head_q.x;
    assign bus.sprite_y     = head_q.y;
    assign bus.sprite_scale = head_q.scale;

`ifdef SPRITE_QUEUE_STATS_EN
    logic [15:0]   dropCount_q, dropCount_d;
    logic [PW-1:0] highWater_q, highWater_d;
    logic [PW-1:0] occupancy_d;

    // Only capacity drops are counted; entries swallowed by discard were never meant to land.
    always_comb begin
        occupancy_d = wrPtr_d - rdPtr_d;
        dropCount_d = dropCount_q;
        if (dropByFull && (dropCount_q != 16'hFFFF)) begin
            dropCount_d = dropCount_q + 16'd1;
        end
        highWater_d = (occupancy_d > highWater_q) ? occupancy_d : highWater_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            dropCount_q <= '0;
            highWater_q <= '0;
        end else begin
            dropCount_q <= dropCount_d;
            highWater_q <= highWater_d;
        end
    end

    assign bus.drop_count = dropCount_q;
    assign bus.high_water = highWater_q;
`endif

endmodule

// File: tb/tb_sprite_draw_queue.sv
// Randomized and directed bench for sprite_draw_queue, checked against a queue-based model
// of staged and committed frames.
module tb_sprite_draw_queue;
    localparam int DEPTH   = 64;
    localparam int ID_W    = 8;
    localparam int POS_W   = 16;
    localparam int SCALE_W = 8;
    localparam int EW      = ID_W + 2 * POS_W + SCALE_W;

    logic clock;
    logic reset;

    sprite_draw_queue_if #(.DEPTH(DEPTH), .ID_W(ID_W), .POS_W(POS_W), .SCALE_W(SCALE_W)) busIf ();

    sprite_draw_queue #(.DEPTH(DEPTH), .ID_W(ID_W), .POS_W(POS_W), .SCALE_W(SCALE_W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (busIf)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checkCount = 0;
    int passCount  = 0;

    logic [EW-1:0] committedQ [$];
    logic [EW-1:0] stagedQ [$];
    logic          modelOverflow;
    logic [EW-1:0] modelHead;
    logic [7:0]    nextId;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        if (observed !== expected) begin
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
        end else begin
            passCount++;
        end
    endtask

    // Frame semantics at the level of whole queues: pop, then stage or drop, then publish or throw away.
    task automatic modelStep(input bit enq, input logic [EW-1:0] data, input bit com, input bit dis, input bit deq);
        bit fullBefore;
        fullBefore = (committedQ.size() + stagedQ.size()) == DEPTH;
        if (deq && committedQ.size() > 0) void'(committedQ.pop_front());
        if (enq && !(dis && !com)) begin
            if (fullBefore) modelOverflow = 1'b1;
            else stagedQ.push_back(data);
        end
        if (com) begin
            foreach (stagedQ[i]) committedQ.push_back(stagedQ[i]);
            stagedQ.delete();
            modelOverflow = 1'b0;
        end else if (dis) begin
            stagedQ.delete();
            modelOverflow = 1'b0;
        end
        if (committedQ.size() > 0) modelHead = committedQ[0];
    endtask

    task automatic checkAll(input string phase);
        logic [EW-1:0] head;
        head = {busIf.sprite_id, busIf.sprite_x, busIf.sprite_y, busIf.sprite_scale};
        checkOutput({phase, "_is_empty"}, 64'(busIf.is_empty), 64'(committedQ.size() == 0));
        checkOutput({phase, "_count"}, 64'(busIf.count), 64'(committedQ.size()));
        checkOutput({phase, "_full"}, 64'(busIf.full), 64'((committedQ.size() + stagedQ.size()) == DEPTH));
        checkOutput({phase, "_overflow"}, 64'(busIf.overflow), 64'(modelOverflow));
        checkOutput({phase, "_head"}, 64'(head), 64'(modelHead));
    endtask

    task automatic applyStimulus(input string phase, input bit enq, input logic [ID_W-1:0] id,
                                 input bit com, input bit dis, input bit deq);
        logic [EW-1:0] data;
        data = {id, POS_W'($urandom), POS_W'($urandom), SCALE_W'($urandom)};
        busIf.enqueue  = enq;
        {busIf.in_id, busIf.in_x, busIf.in_y, busIf.in_scale} = data;
        busIf.commit   = com;
        busIf.discard  = dis;
        busIf.dequeue  = deq;
        @(posedge clock);
        #1;
        modelStep(enq, data, com, dis, deq);
        busIf.enqueue = 1'b0;
        busIf.commit  = 1'b0;
        busIf.discard = 1'b0;
        busIf.dequeue = 1'b0;
        checkAll(phase);
    endtask

    task automatic doReset(input string phase);
        reset = 1'b1;
        busIf.enqueue = 1'b0;
        busIf.commit  = 1'b0;
        busIf.discard = 1'b0;
        busIf.dequeue = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b0;
        committedQ.delete();
        stagedQ.delete();
        modelOverflow = 1'b0;
        modelHead     = '0;
        checkAll(phase);
    endtask

    initial begin
        {busIf.in_id, busIf.in_x, busIf.in_y, busIf.in_scale} = '0;
        doReset("reset");

        // Staged entries stay hidden until commit.
        for (int i = 1; i <= 3; i++) applyStimulus("stage", 1'b1, ID_W'(i), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) applyStimulus("hidden", 1'b0, '0, 1'b0, 1'b0, 1'b0);
        checkOutput("hidden_empty_const", 64'(busIf.is_empty), 64'd1);
        applyStimulus("commit", 1'b0, '0, 1'b1, 1'b0, 1'b0);
        checkOutput("commit_head_id1", 64'(busIf.sprite_id), 64'd1);
        for (int i = 0; i < 3; i++) applyStimulus("drain", 1'b0, '0, 1'b0, 1'b0, 1'b1);
        checkOutput("drain_empty_const", 64'(busIf.is_empty), 64'd1);

        // Discarded frame never shows; a commit with same-cycle enqueue publishes that entry.
        applyStimulus("disc_enq", 1'b1, 8'd7, 1'b0, 1'b0, 1'b0);
        applyStimulus("discard", 1'b0, '0, 1'b0, 1'b1, 1'b0);
        applyStimulus("enq_commit", 1'b1, 8'd9, 1'b1, 1'b0, 1'b0);
        checkOutput("disc_head_id9", 64'(busIf.sprite_id), 64'd9);
        checkOutput("disc_count1", 64'(busIf.count), 64'd1);
        applyStimulus("disc_pop", 1'b0, '0, 1'b0, 1'b0, 1'b1);
        applyStimulus("pop_empty", 1'b0, '0, 1'b0, 1'b0, 1'b1);

        // Fill to capacity, overflow by one, publish and pop everything in order.
        for (int i = 0; i < DEPTH; i++) applyStimulus("fill", 1'b1, ID_W'(i + 100), 1'b0, 1'b0, 1'b0);
        checkOutput("fill_full_const", 64'(busIf.full), 64'd1);
        applyStimulus("over", 1'b1, 8'hEE, 1'b0, 1'b0, 1'b0);
        checkOutput("over_flag_const", 64'(busIf.overflow), 64'd1);
        applyStimulus("fill_commit", 1'b0, '0, 1'b1, 1'b0, 1'b0);
        checkOutput("fill_count", 64'(busIf.count), 64'(DEPTH));
        for (int i = 0; i < DEPTH; i++) applyStimulus("fill_pop", 1'b0, '0, 1'b0, 1'b0, 1'b1);

        // Random traffic across pointer wrap, including pops on an empty queue.
        nextId = 8'd1;
        for (int i = 0; i < 200; i++) begin
            bit enq, com, dis, deq;
            enq = ($urandom_range(99) < 60);
            com = ($urandom_range(99) < 15);
            dis = ($urandom_range(99) < 5);
            deq = ($urandom_range(99) < 50);
            applyStimulus("rand", enq, nextId, com, dis, deq);
            if (enq) nextId++;
        end

        // Reset in the middle of a frame with committed and staged entries outstanding.
        doReset("mid_clr");
        for (int i = 0; i < 5; i++) applyStimulus("mid_c", 1'b1, ID_W'(i + 40), 1'b0, 1'b0, 1'b0);
        applyStimulus("mid_commit", 1'b0, '0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus("mid_s", 1'b1, ID_W'(i + 50), 1'b0, 1'b0, 1'b0);
        doReset("mid_reset");
        checkOutput("mid_reset_id_zero", 64'(busIf.sprite_id), 64'd0);
        checkOutput("mid_reset_count_zero", 64'(busIf.count), 64'd0);
`ifdef SPRITE_QUEUE_STATS_EN
        checkOutput("mid_reset_drop_count", 64'(busIf.drop_count), 64'd0);
`endif

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
